dmem_byte_ctrl: RTL and testbench

DMEM_BYTE_CTRL -- requirements
Module: dmem_byte_ctrl

---
 rtl/dmem_byte_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dmem_byte_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_byte_ctrl.sv
// Byte/half/word addressable data memory with alignment and IO-region fault detection.
// Optional power-up clearing of every word is enabled by defining DMEM_ZERO_ON_RESET_EN.
module dmem_byte_ctrl #(
  parameter int          RAM_SIZE     = 256,
  parameter int          RAM_SIZE_BIT = 8,
  parameter logic [3:0]  IO_TAG       = 4'h4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [2:0]  mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam logic [2:0] MODE_WORD = 3'b000;
  localparam logic [2:0] MODE_HS   = 3'b001;
  localparam logic [2:0] MODE_HU   = 3'b010;
  localparam logic [2:0] MODE_BS   = 3'b011;
  localparam logic [2:0] MODE_BU   = 3'b100;

  logic [31:0]             mem [RAM_SIZE];
  logic [RAM_SIZE_BIT-1:0] word_idx;
  logic [31:0]             cur_word;
  logic [31:0]             lane_data;
  logic [31:0]             merged_word;
  logic [31:0]             rd_val;
  logic [7:0]              lane_byte;
  logic [15:0]             lane_half;
  logic [3:0]              byte_en;
  logic                    strobe;
  logic                    misalign;
  logic                    access_ok;
  logic                    we;
  logic                    mem_we;
  logic [RAM_SIZE_BIT-1:0] mem_widx;
  logic [31:0]             mem_wdata;
  logic                    fault_seen_reg;
  logic [31:0]             fault_addr_reg;
  logic                    unused_addr_bits;

  // Upper address bits below the IO tag simply alias onto the RAM.
  assign unused_addr_bits = ^addr[27:RAM_SIZE_BIT+2];

  assign word_idx  = addr[RAM_SIZE_BIT+1:2];
  assign cur_word  = mem[word_idx];
  assign strobe    = (rd | wr) & reset;

  always_comb begin
    misalign = 1'b0;
    case (mode)
      MODE_WORD:       misalign = (addr[1:0] != 2'b00);
      MODE_HS, MODE_HU: misalign = addr[0];
      default:         misalign = 1'b0;
    endcase
  end

  assign fault     = strobe & ((addr[31:28] == IO_TAG) | (mode > MODE_BU) | misalign);
  assign access_ok = reset & ~fault & ~busy;
  assign we        = wr & access_ok;

  assign lane_byte = cur_word[{addr[1:0], 3'b000} +: 8];
  assign lane_half = addr[1] ? cur_word[31:16] : cur_word[15:0];

  always_comb begin
    rd_val = 32'h0;
    case (mode)
      MODE_WORD: rd_val = cur_word;
      MODE_HS:   rd_val = {{16{lane_half[15]}}, lane_half};
      MODE_HU:   rd_val = {16'h0, lane_half};
      MODE_BS:   rd_val = {{24{lane_byte[7]}}, lane_byte};
      MODE_BU:   rd_val = {24'h0, lane_byte};
      default:   rd_val = 32'h0;
    endcase
  end

  assign rdata = (rd & access_ok) ? rd_val : 32'h0;

  // Store data is replicated into every lane so the byte enables alone pick the target.
  always_comb begin
    lane_data = {4{wdata[7:0]}};
    byte_en   = 4'b0000;
    case (mode)
      MODE_WORD: begin
        lane_data = wdata;
        byte_en   = 4'b1111;
      end
      MODE_HS, MODE_HU: begin
        lane_data = {2{wdata[15:0]}};
        byte_en   = addr[1] ? 4'b1100 : 4'b0011;
      end
      MODE_BS, MODE_BU: begin
        lane_data = {4{wdata[7:0]}};
        byte_en   = 4'b0001 << addr[1:0];
      end
      default: begin
        lane_data = {4{wdata[7:0]}};
        byte_en   = 4'b0000;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = byte_en[gi] ? lane_data[8*gi +: 8] : cur_word[8*gi +: 8];
    end
  endgenerate

`ifdef DMEM_ZERO_ON_RESET_EN
  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                  state_reg;
  logic [RAM_SIZE_BIT-1:0] clr_cnt_reg;
  logic                    busy_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= '0;
      busy_reg    <= 1'b1;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == RAM_SIZE_BIT'(RAM_SIZE - 1)) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign mem_we    = busy_reg | we;
  assign mem_widx  = busy_reg ? clr_cnt_reg : word_idx;
  assign mem_wdata = busy_reg ? 32'h0 : merged_word;
`else
  assign busy      = 1'b0;
  assign mem_we    = we;
  assign mem_widx  = word_idx;
  assign mem_wdata = merged_word;
`endif

  // Contents are deliberately not reset so they survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_seen_reg <= 1'b0;
      fault_addr_reg <= 32'h0;
    end else if (fault && !busy && !fault_seen_reg) begin
      fault_seen_reg <= 1'b1;
      fault_addr_reg <= addr;
    end
  end

  assign fault_addr = fault_addr_reg;

endmodule

// File: tb/tb_dmem_byte_ctrl.sv
// Randomized self-checking bench for dmem_byte_ctrl against a byte-array reference model.
// Adapts its reset/clear expectations to DMEM_ZERO_ON_RESET_EN.
module tb_dmem_byte_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        busy;
  logic        fault;
  logic [31:0] fault_addr;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  ref_b [0:1023];
  logic        ref_seen;
  logic [31:0] ref_faddr;
  logic        quiet = 1'b0;

  dmem_byte_ctrl #(.RAM_SIZE(256), .RAM_SIZE_BIT(8), .IO_TAG(4'h4)) dut (
    .clk        (clk),
    .reset      (reset),
    .rd         (rd),
    .wr         (wr),
    .mode       (mode),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .busy       (busy),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_fault(input logic r, input logic w, input logic [2:0] m,
                                       input logic [31:0] a);
    logic bad;
    bad = (a[31:28] == 4'h4) || (m > 3'd4) ||
          (m == 3'd0 && a[1:0] != 2'b00) ||
          ((m == 3'd1 || m == 3'd2) && a[0]);
    return (r || w) && bad;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] m, input logic [31:0] a);
    int ba;
    ba = int'(a[9:0]);
    case (m)
      3'd0: return {ref_b[ba+3], ref_b[ba+2], ref_b[ba+1], ref_b[ba]};
      3'd1: return {{16{ref_b[ba+1][7]}}, ref_b[ba+1], ref_b[ba]};
      3'd2: return {16'h0, ref_b[ba+1], ref_b[ba]};
      3'd3: return {{24{ref_b[ba][7]}}, ref_b[ba]};
      3'd4: return {24'h0, ref_b[ba]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
    int ba;
    int nb;
    ba = int'(a[9:0]);
    nb = (m == 3'd0) ? 4 : ((m <= 3'd2) ? 2 : 1);
    for (int k = 0; k < nb; k++) ref_b[ba+k] = d[8*k +: 8];
  endtask

  task automatic model_zero();
    for (int i = 0; i < 1024; i++) ref_b[i] = 8'h00;
  endtask

  // One memory access: check combinational outputs mid-cycle, commit at the edge.
  task automatic access(input logic r, input logic w, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] d, output logic [31:0] obs);
    logic        f;
    logic [31:0] exp_rd;
    @(negedge clk);
    rd = r; wr = w; mode = m; addr = a; wdata = d;
    #1;
    f      = model_fault(r, w, m, a);
    exp_rd = (r && !f) ? model_read(m, a) : 32'h0;
    obs    = rdata;
    check("fault", {31'h0, fault}, {31'h0, f});
    check("rdata", rdata, exp_rd);
    check("busy", {31'h0, busy}, 32'h0);
    if (!quiet)
      $display("txn rd=%0b wr=%0b mode=%0d addr=%h wdata=%h rdata=%h fault=%0b faddr=%h",
               r, w, m, a, d, rdata, fault, fault_addr);
    @(posedge clk);
    #1;
    if (w && !f) model_write(m, a, d);
    if (f && !ref_seen) begin
      ref_seen  = 1'b1;
      ref_faddr = a;
    end
    check("fault_addr", fault_addr, ref_faddr);
    rd = 1'b0; wr = 1'b0;
  endtask

  // Counts busy cycles after release; pokes a write to 0x8 while busy; can stop early.
  task automatic wait_clear(input int stop_at, output int cnt);
    cnt = 0;
    check("busy_at_release", {31'h0, busy}, 32'h1);
    while (busy && cnt < 1000 && cnt != stop_at) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 5) begin
        rd = 1'b1; wr = 1'b1; mode = 3'd0; addr = 32'h8; wdata = 32'hDEADBEEF;
        #1;
        check("busy_rdata", rdata, 32'h0);
        check("busy_fault", {31'h0, fault}, 32'h0);
      end else if (cnt == 6) begin
        rd = 1'b0; wr = 1'b0;
      end
    end
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic reset_pulse(input int low_cycles);
    int cnt;
    @(negedge clk);
    reset = 1'b0; rd = 1'b1; wr = 1'b0; mode = 3'd0; addr = 32'h40000000;
    repeat (low_cycles) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);
    check("rst_faddr", fault_addr, 32'h0);
    rd = 1'b0;
    reset = 1'b1;
    ref_seen  = 1'b0;
    ref_faddr = 32'h0;
`ifdef DMEM_ZERO_ON_RESET_EN
    wait_clear(-1, cnt);
    check("busy_cycles", cnt, 256);
    model_zero();
`else
    #1;
    check("busy_off", {31'h0, busy}, 32'h0);
`endif
  endtask

  initial begin
    logic [31:0] obs;
    logic [31:0] a;
    logic [2:0]  m;
    int          cnt;

    ref_seen  = 1'b0;
    ref_faddr = 32'h0;
    for (int i = 0; i < 1024; i++) ref_b[i] = 8'h00;

    reset_pulse(3);

`ifdef DMEM_ZERO_ON_RESET_EN
    access(1, 0, 3'd0, 32'h000003FC, 32'h0, obs);
    check("clr_3fc", obs, 32'h0);
    access(1, 0, 3'd0, 32'h00000008, 32'h0, obs);
    check("busy_wr_ignored", obs, 32'h0);
    // Interrupt the clear sequence partway through and confirm it restarts.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wait_clear(100, cnt);
    check("mid_clear_cnt", cnt, 100);
    check("mid_clear_busy", {31'h0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_clear(-1, cnt);
    check("restart_cycles", cnt, 256);
`else
    quiet = 1'b1;
    for (int i = 0; i < 256; i++) access(0, 1, 3'd0, 32'(i * 4), $urandom, obs);
    quiet = 1'b0;
`endif

    access(0, 1, 3'd0, 32'h10, 32'h11223344, obs);
    access(0, 1, 3'd3, 32'h11, 32'h000000AA, obs);
    access(1, 0, 3'd0, 32'h10, 32'h0, obs);
    check("lw_10", obs, 32'h1122AA44);
    access(1, 0, 3'd3, 32'h11, 32'h0, obs);
    check("lb_11", obs, 32'hFFFFFFAA);
    access(1, 0, 3'd4, 32'h11, 32'h0, obs);
    check("lbu_11", obs, 32'h000000AA);

    access(0, 1, 3'd0, 32'h20, 32'h5A5A1234, obs);
    access(0, 1, 3'd1, 32'h22, 32'h00008001, obs);
    access(1, 0, 3'd1, 32'h22, 32'h0, obs);
    check("lh_22", obs, 32'hFFFF8001);
    access(1, 0, 3'd2, 32'h22, 32'h0, obs);
    check("lhu_22", obs, 32'h00008001);
    access(1, 0, 3'd0, 32'h20, 32'h0, obs);
    check("lw_20_low", {16'h0, obs[15:0]}, 32'h00001234);

    access(0, 1, 3'd0, 32'h40000000, 32'hFFFFFFFF, obs);
    access(1, 0, 3'd1, 32'h13, 32'h0, obs);
    check("faddr_first", fault_addr, 32'h40000000);
    access(1, 0, 3'd0, 32'h10, 32'h0, obs);
    check("lw_10_kept", obs, 32'h1122AA44);

    access(0, 1, 3'd0, 32'h30, 32'h12345678, obs);
    access(1, 1, 3'd0, 32'h30, 32'hCAFEF00D, obs);
    check("rdwr_old", obs, 32'h12345678);
    access(1, 0, 3'd0, 32'h0FF00030, 32'h0, obs);
    check("rdwr_new_alias", obs, 32'hCAFEF00D);

    for (int t = 0; t < 300; t++) begin
      m = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      a = $urandom;
      a[31:28] = ($urandom_range(0, 7) == 0) ? 4'h4 : 4'h1;
      if ($urandom_range(0, 4) != 0) begin
        if (m == 3'd0) a[1:0] = 2'b00;
        else if (m == 3'd1 || m == 3'd2) a[0] = 1'b0;
      end
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), m, a, $urandom, obs);
    end

    reset_pulse(2);
    access(1, 0, 3'd0, 32'h10, 32'h0, obs);
    access(0, 1, 3'd2, 32'h00000101, 32'h0, obs);
    check("faddr_after_rst", fault_addr, 32'h00000101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
